// File: rtl/monster_slot.sv
// One monster slot: spawns at an LFSR-derived X, marches down once per frame, dies or escapes.
// Optional horizontal zig-zag drift is enabled by defining MONSTER_ZIGZAG_EN.
module monster_slot #(
  parameter int         START_Y      = 0,
  parameter int         BOTTOM_Y     = 479,
  parameter int         STEP         = 1,
  parameter int         X_MIN        = 0,
  parameter int         X_MAX        = 607,
  parameter int         DEATH_FRAMES = 8,
  parameter logic [9:0] LFSR_SEED    = 10'h2A5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       spawn,
  input  logic       hit,
  output logic [9:0] monster_x,
  output logic [9:0] monster_y,
  output logic       active,
  output logic       exploding,
  output logic       monster_done,
  output logic       escaped
);

  localparam int CW = $clog2(DEATH_FRAMES) + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DYING} state_t;

  state_t        state, state_nxt;
  logic          frame_clk_d;
  logic [9:0]    lfsr;
  logic [CW-1:0] cnt;
  logic          frame_tick;
  logic [10:0]   y_sum;
  logic [10:0]   spawn_x_raw;
  logic [9:0]    spawn_x;
  logic          escape_now;
  logic          active_nxt, exploding_nxt, done_nxt, escaped_nxt;
`ifdef MONSTER_ZIGZAG_EN
  logic          dir;
`endif

  assign frame_tick  = frame_clk & ~frame_clk_d;
  // 11-bit sum so a position near the bottom cannot wrap and sneak past the compare
  assign y_sum       = {1'b0, monster_y} + 11'(STEP);
  assign spawn_x_raw = 11'(X_MIN) + {2'b00, lfsr[8:0]};
  assign spawn_x     = (spawn_x_raw > 11'(X_MAX)) ? 10'(X_MAX) : spawn_x_raw[9:0];
  assign escape_now  = (state == ACTIVE) && !hit && frame_tick && (y_sum > 11'(BOTTOM_Y));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (spawn) state_nxt = ACTIVE;
      ACTIVE:  if (hit) state_nxt = DYING;
               else if (escape_now) state_nxt = IDLE;
      DYING:   if (frame_tick && cnt == CW'(DEATH_FRAMES - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    active_nxt    = (state_nxt == ACTIVE);
    exploding_nxt = (state_nxt == DYING);
    done_nxt      = (state_nxt == IDLE);
    escaped_nxt   = escape_now;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= IDLE;
      frame_clk_d  <= 1'b0;
      lfsr         <= LFSR_SEED;
      cnt          <= '0;
      monster_x    <= '0;
      monster_y    <= '0;
      active       <= 1'b0;
      exploding    <= 1'b0;
      monster_done <= 1'b1;
      escaped      <= 1'b0;
`ifdef MONSTER_ZIGZAG_EN
      dir          <= LFSR_SEED[9];
`endif
    end else begin
      state        <= state_nxt;
      frame_clk_d  <= frame_clk;
      lfsr         <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      active       <= active_nxt;
      exploding    <= exploding_nxt;
      monster_done <= done_nxt;
      escaped      <= escaped_nxt;
      unique case (state)
        IDLE: if (spawn) begin
          monster_x <= spawn_x;
          monster_y <= 10'(START_Y);
`ifdef MONSTER_ZIGZAG_EN
          dir       <= lfsr[9];
`endif
        end
        ACTIVE: begin
          if (hit) cnt <= '0;
          else if (frame_tick) begin
            if (!escape_now) monster_y <= y_sum[9:0];
`ifdef MONSTER_ZIGZAG_EN
            // dir=1 drifts right; the bound reached on this tick flips direction
            if (dir) begin
              if (monster_x >= 10'(X_MAX)) begin
                monster_x <= monster_x - 10'd1;
                dir       <= 1'b0;
              end else begin
                monster_x <= monster_x + 10'd1;
                if (monster_x + 10'd1 >= 10'(X_MAX)) dir <= 1'b0;
              end
            end else begin
              if (monster_x <= 10'(X_MIN)) begin
                monster_x <= monster_x + 10'd1;
                dir       <= 1'b1;
              end else begin
                monster_x <= monster_x - 10'd1;
                if (monster_x - 10'd1 <= 10'(X_MIN)) dir <= 1'b1;
              end
            end
`endif
          end
        end
        DYING: if (frame_tick) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_monster_slot.sv
// Randomized bench for monster_slot against a frame-level behavioural model, plus pinned literals.
module tb_monster_slot;
  localparam int START_Y = 0, BOTTOM_Y = 10, STEP = 3, X_MIN = 0, X_MAX = 607, DF = 8;
  localparam logic [9:0] SEED = 10'h2A5;

  logic Clk = 0, Reset, frame_clk, spawn, hit;
  logic [9:0] monster_x, monster_y;
  logic active, exploding, monster_done, escaped;

  monster_slot #(.START_Y(START_Y), .BOTTOM_Y(BOTTOM_Y), .STEP(STEP), .X_MIN(X_MIN),
                 .X_MAX(X_MAX), .DEATH_FRAMES(DF), .LFSR_SEED(SEED)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .spawn(spawn), .hit(hit),
    .monster_x(monster_x), .monster_y(monster_y), .active(active), .exploding(exploding),
    .monster_done(monster_done), .escaped(escaped));

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;
  bit cmp_en = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: slot is free(0)/alive(1)/dying(2); frames counted as vsync rising edges.
  int m_st = 0, m_x = 0, m_y = 0, m_frames = 0, m_lfsr = int'(SEED), m_prev = 0, m_esc = 0;
  int m_dir = int'(SEED[9]);
  always @(posedge Clk) begin
    int tick, fb;
    if (!Reset) begin
      m_st = 0; m_x = 0; m_y = 0; m_frames = 0; m_lfsr = int'(SEED); m_prev = 0; m_esc = 0;
      m_dir = int'(SEED[9]);
    end else begin
      tick = (frame_clk && !m_prev) ? 1 : 0;
      m_prev = frame_clk;
      m_esc = 0;
      if (m_st == 0) begin
        if (spawn) begin
          m_x = X_MIN + (m_lfsr % 512);
          if (m_x > X_MAX) m_x = X_MAX;
          m_y = START_Y; m_st = 1; m_dir = m_lfsr / 512;
        end
      end else if (m_st == 1) begin
        if (hit) begin m_st = 2; m_frames = 0; end
        else if (tick) begin
          if (m_y + STEP > BOTTOM_Y) begin m_esc = 1; m_st = 0; end
          else m_y = m_y + STEP;
`ifdef MONSTER_ZIGZAG_EN
          if (m_dir == 1) begin
            if (m_x >= X_MAX) begin m_x--; m_dir = 0; end
            else begin m_x++; if (m_x >= X_MAX) m_dir = 0; end
          end else begin
            if (m_x <= X_MIN) begin m_x++; m_dir = 1; end
            else begin m_x--; if (m_x <= X_MIN) m_dir = 1; end
          end
`endif
        end
      end else if (tick) begin
        m_frames++;
        if (m_frames == DF) m_st = 0;
      end
      fb = ((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1;
      m_lfsr = ((m_lfsr * 2) + fb) % 1024;
    end
  end

  always @(negedge Clk) if (cmp_en) begin
    chk("x", monster_x, m_x);
    chk("y", monster_y, m_y);
    chk("active", active, m_st == 1);
    chk("exploding", exploding, m_st == 2);
    chk("done", monster_done, m_st == 0);
    chk("escaped", escaped, m_esc);
  end

  task automatic cyc();
    @(posedge Clk); #2;
  endtask

  task automatic tick();
    frame_clk = 1; repeat (3) cyc();
    frame_clk = 0; repeat (2) cyc();
  endtask

  task automatic pulse_spawn();
    spawn = 1; cyc(); spawn = 0;
  endtask

  initial begin
    Reset = 0; frame_clk = 0; spawn = 0; hit = 0;
    repeat (3) cyc();
    cmp_en = 1;
    Reset = 1;
    @(negedge Clk);
    chk("rst_done", monster_done, 1); chk("rst_active", active, 0);
    chk("rst_esc", escaped, 0); chk("rst_x", monster_x, 0); chk("rst_y", monster_y, 0);

    cyc(); pulse_spawn();
    @(negedge Clk);
    chk("spawn_active", active, 1); chk("spawn_y", monster_y, 0);
    chk("spawn_done", monster_done, 0); chk("spawn_xrange", int'(monster_x <= 10'd607), 1);

    // march 0,3,6,9 then escape on the 4th tick
    cyc(); tick();
    chk("y_tick1", monster_y, 3);
    tick(); tick();
    chk("y_tick3", monster_y, 9);
    frame_clk = 1; cyc();
    @(negedge Clk); chk("esc_pulse", escaped, 1);
    cyc();
    @(negedge Clk); chk("esc_gone", escaped, 0); chk("esc_done", monster_done, 1);
    chk("esc_yhold", monster_y, 9);
    cyc(); frame_clk = 0; repeat (2) cyc();

    // hit coincident with a tick: hit wins, then 8 ticks of animation
    pulse_spawn(); tick(); tick();
    frame_clk = 1; hit = 1; cyc(); hit = 0;
    @(negedge Clk); chk("hit_y", monster_y, 6); chk("hit_expl", exploding, 1);
    chk("hit_active", active, 0);
    cyc(); cyc(); frame_clk = 0; repeat (2) cyc();
    hit = 1; cyc(); hit = 0;
    repeat (7) tick();
    chk("dying_7", exploding, 1);
    tick();
    chk("dying_done", monster_done, 1); chk("dying_expl", exploding, 0);

    // spawn while alive is ignored; reset mid-death drops the slot
    pulse_spawn(); tick(); pulse_spawn();
    @(negedge Clk); chk("respawn_y", monster_y, 3); chk("respawn_active", active, 1);
    cyc(); hit = 1; cyc(); hit = 0; tick();
    Reset = 0; cyc(); Reset = 1;
    @(negedge Clk); chk("rst_dying_done", monster_done, 1); chk("rst_dying_esc", escaped, 0);
    chk("rst_dying_x", monster_x, 0);

    repeat (4000) begin
      cyc();
      if ($urandom_range(2) == 0) frame_clk = ~frame_clk;
      spawn = ($urandom_range(5) == 0);
      hit   = ($urandom_range(19) == 0);
      Reset = ($urandom_range(399) != 0);
    end
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/monster_slot.md
Name: monster_slot

Overview:
- One monster instance slot, directly downstream of the monster spawn controller. Four copies are instantiated.
- Consumes one bit of the controller's one-hot spawn select. Spawns a monster at a pseudo-random X and marches it down the screen once per frame.
- Handles bullet hits and the death animation, and reports slot-free status back to the controller as monster_done.

Parameters:
- START_Y, 0: Y coordinate of a freshly spawned monster.
- BOTTOM_Y, 479: last valid Y. A monster whose next position would exceed this escapes.
- STEP, 1: pixels moved down per frame tick.
- X_MIN, 0: leftmost spawn/drift X.
- X_MAX, 607: rightmost spawn/drift X.
- DEATH_FRAMES, 8: number of frame ticks spent in the death animation.
- LFSR_SEED, 10'h2A5: reset value of the internal LFSR. Must be nonzero. Use a different value per instance.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-low reset.
- frame_clk  in  1  VGA vsync-rate strobe. Level input; rising edge detected internally.
- spawn  in  1  one-cycle spawn request (one bit of the controller's select).
- hit  in  1  collision flag from the bullet/monster collision logic.
- monster_x  out  10  current X.
- monster_y  out  10  current Y.
- active  out  1  monster alive and drawable.
- exploding  out  1  death animation in progress.
- monster_done  out  1  slot free (IDLE). Feeds the controller.
- escaped  out  1  one-cycle pulse when a monster leaves the bottom (player damage).

Behaviour:
- All state is updated on posedge Clk. Reset is sampled only at a clock edge.
- Reset (Reset==0):
  - state=IDLE, monster_x=0, monster_y=0.
  - active=0, exploding=0, escaped=0, monster_done=1.
  - lfsr=LFSR_SEED, death counter=0, frame_clk_d=0.
  - Reset mid-operation drops any live monster with no escaped pulse.
- frame_tick = frame_clk & ~frame_clk_d, where frame_clk_d is a one-register delay. One tick per vsync rising edge.
- LFSR:
  - 10-bit Fibonacci, polynomial x^10+x^7+1.
  - Shifts every clock out of reset, independent of state.
- All outputs are registered. They reflect the state entered on the previous edge.
- FSM states: IDLE, ACTIVE, DYING.
- IDLE:
  - monster_done=1, active=0, exploding=0.
  - On spawn: latch monster_x = X_MIN + lfsr[8:0], saturated to X_MAX if larger. Set monster_y=START_Y and go to ACTIVE.
  - monster_done drops to 0 on the same edge the spawn is taken. Latency from spawn to active=1 is one clock.
  - spawn in ACTIVE or DYING is ignored, with no queuing.
- ACTIVE:
  - active=1, monster_done=0.
  - Priority each cycle: hit > frame-tick movement.
  - hit=1: go to DYING, clear the death counter, active=0 and exploding=1 next cycle. Position is frozen.
  - frame_tick without hit:
    - If monster_y + STEP > BOTTOM_Y (compare at 11 bits, no wrap): escaped=1 for exactly one cycle, go to IDLE, monster_done=1 next cycle.
    - Otherwise monster_y += STEP.
  - hit and frame_tick in the same cycle: the hit wins, so there is no move and no escape.
- DYING:
  - exploding=1, active=0, monster_done=0. hit is ignored.
  - On each frame_tick the counter increments. When counter == DEATH_FRAMES-1 on a tick, go to IDLE.
  - The animation lasts exactly DEATH_FRAMES ticks.
- escaped is 0 in every cycle except the single escape cycle.

Optional Feature:
- Macro: MONSTER_ZIGZAG_EN.
- When defined:
  - A 1-bit direction register is added. Reset and spawn set it to direction = lfsr[9].
  - In ACTIVE, each frame_tick also moves monster_x by 1 toward the current direction.
  - Reaching X_MIN or X_MAX reverses the direction on the same tick, so X never leaves [X_MIN, X_MAX].
  - Horizontal drift is frozen in DYING.
- When undefined: monster_x stays constant from spawn until the next spawn, and no direction register exists.

Test Plan:
- Reset held low 3 cycles, then released → monster_done=1, active=0, escaped=0, x=y=0. Next spawn pulse → active=1 one clock later, monster_y=0, monster_x in [0,607], monster_done=0.
- Spawn, then 5 frame_clk rising edges (level held high across several clocks each) → monster_y=5 exactly, one increment per edge.
- BOTTOM_Y=10, STEP=3: spawn, then ticks → y goes 0,3,6,9. The 4th tick (9+3>10) → escaped high for exactly 1 cycle, then monster_done=1, y held at 9.
- Spawn, 2 ticks, hit asserted in the same cycle as a tick → y stays 2, exploding=1. After 8 more ticks → IDLE, monster_done=1. hit pulses during DYING cause no change.
- Spawn pulse while ACTIVE → ignored (x, y unchanged). Reset pulled low mid-DYING → IDLE next edge, no escaped pulse.
- With MONSTER_ZIGZAG_EN, X_MIN=0, X_MAX=3 → x stays within 0..3 and reverses at each bound across 10 ticks.
